// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous first-word-fall-through FIFO.
// Holds the default geometry and the pointer width derived from the depth.
package fifo_pkg;

  localparam int DEFAULT_FIFO_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 256;
  localparam int DEFAULT_PTR_W      = $clog2(DEFAULT_FIFO_DEPTH);

  // Pointer width for an arbitrary depth; occupancy needs one extra bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// The asynchronous read is what lets the head entry fall through with zero latency.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_FIFO_WIDTH,
  parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W = DEFAULT_PTR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock FWFT FIFO with valid/ready on both sides.
// Pointers wrap naturally; an extra count bit distinguishes full from empty.
module fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  output logic                  readReady,
  output logic                  writeReady,
  input  logic                  readValid,
  input  logic                  writeValid,
  input  logic [FIFO_WIDTH-1:0] writeData,
  output logic [FIFO_WIDTH-1:0] readData,
  input  logic                  clk,
  input  logic                  rst
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_en, rd_en;
  logic [FIFO_WIDTH-1:0] mem_rd_data;

  // Readies depend only on registered state, never on the same-cycle valids.
  assign writeReady = !rst && (count_q != FULL_COUNT);
  assign readReady  = !rst && (count_q != '0);
  assign wr_en      = writeValid && writeReady;
  assign rd_en      = readValid && readReady;
  assign readData   = readReady ? mem_rd_data : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (writeData),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

endmodule : fifo

// File: tb/tb_fifo.sv
// Directed and scoreboarded checks for the FWFT FIFO at its default geometry.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fifo;

  localparam int W = 8;
  localparam int D = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         readReady, writeReady;
  logic         readValid, writeValid;
  logic [W-1:0] writeData, readData;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q[$];

  fifo dut (
    .readReady  (readReady),
    .writeReady (writeReady),
    .readValid  (readValid),
    .writeValid (writeValid),
    .writeData  (writeData),
    .readData   (readData),
    .clk        (clk),
    .rst        (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    writeValid = 1'b1;
    writeData  = d;
    tick();
    writeValid = 1'b0;
    $display("write %02h writeReady_after=%0b readReady_after=%0b", d, writeReady, readReady);
  endtask

  task automatic pop();
    $display("read  %02h", readData);
    readValid = 1'b1;
    tick();
    readValid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    readValid  = 1'b0;
    writeValid = 1'b0;
    writeData  = '0;

    // Reset held for two cycles
    tick();
    check("rst_readReady", readReady, 0);
    check("rst_writeReady", writeReady, 0);
    check("rst_readData", readData, 0);
    tick();
    check("rst2_writeReady", writeReady, 0);
    rst = 1'b0;
    #1;
    check("rel_writeReady", writeReady, 1);
    check("rel_readReady", readReady, 0);

    // Single transfer
    push(8'hA5);
    check("single_readReady", readReady, 1);
    check("single_readData", readData, 8'hA5);
    pop();
    check("single_empty", readReady, 0);
    check("single_zero_data", readData, 0);

    // Fill to full
    for (int i = 0; i < D; i++) begin
      check("fill_writeReady", writeReady, 1);
      push(8'(i));
    end
    check("full_writeReady", writeReady, 0);
    check("full_readReady", readReady, 1);
    push(8'hFF);
    check("overflow_writeReady", writeReady, 0);
    check("overflow_head", readData, 8'h00);

    // Full with simultaneous read and write: only the pop happens
    readValid  = 1'b1;
    writeValid = 1'b1;
    writeData  = 8'hEE;
    tick();
    readValid  = 1'b0;
    writeValid = 1'b0;
    $display("read  00 with dropped write ee");
    check("fullrw_writeReady", writeReady, 1);
    check("fullrw_head", readData, 8'h01);
    for (int i = 1; i < D; i++) begin
      check("drain_data", readData, 32'(i));
      pop();
    end
    check("drain_empty", readReady, 0);
    check("drain_writeReady", writeReady, 1);

    // Empty with simultaneous read and write: write accepted, read ignored
    readValid  = 1'b1;
    writeValid = 1'b1;
    writeData  = 8'h77;
    tick();
    readValid  = 1'b0;
    writeValid = 1'b0;
    $display("write 77 with ignored read on empty");
    check("emptyrw_readReady", readReady, 1);
    check("emptyrw_data", readData, 8'h77);
    pop();
    check("emptyrw_drain", readReady, 0);

    // Randomised traffic against a scoreboard queue
    for (int c = 0; c < 50000; c++) begin
      logic wv, rv, wacc, racc;
      logic [W-1:0] d;
      wv = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 2) == 0);
      d  = 8'($urandom);
      check("rnd_readReady", readReady, (model_q.size() != 0) ? 1 : 0);
      check("rnd_writeReady", writeReady, (model_q.size() != D) ? 1 : 0);
      if (model_q.size() != 0) check("rnd_data", readData, model_q[0]);
      else                     check("rnd_zero_data", readData, 0);
      wacc = wv && (model_q.size() < D);
      racc = rv && (model_q.size() > 0);
      writeValid = wv;
      readValid  = rv;
      writeData  = d;
      tick();
      if (racc) void'(model_q.pop_front());
      if (wacc) model_q.push_back(d);
    end
    writeValid = 1'b0;
    readValid  = 1'b0;
    $display("random phase done, %0d entries still queued", model_q.size());

    // Reset mid-stream with 10 entries queued
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    check("mid_queued_head", readData, 8'h40);
    rst = 1'b1;
    tick();
    check("mid_rst_readReady", readReady, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_readReady", readReady, 0);
    check("mid_rel_writeReady", writeReady, 1);
    push(8'h3C);
    check("mid_first_readReady", readReady, 1);
    check("mid_first_data", readData, 8'h3C);
    pop();
    check("mid_final_empty", readReady, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO with valid/ready handshakes on both the write and read sides.
- Data is first-word-fall-through: the head entry is visible on readData whenever the FIFO is non-empty.
- It is a generic buffering block between a producer and a consumer running on the same clock.
- Capacity is FIFO_DEPTH entries of FIFO_WIDTH bits.

Parameters:
- FIFO_WIDTH, 8, data width in bits.
- FIFO_DEPTH, 256, number of entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- readReady  output  1  FIFO is non-empty; readData holds a valid head entry.
- writeReady  output  1  FIFO is not full; a write is accepted this cycle if writeValid=1.
- readValid  input  1  consumer requests a pop.
- writeValid  input  1  producer offers writeData.
- writeData  input  FIFO_WIDTH  data to push.
- readData  output  FIFO_WIDTH  head-of-queue data (first-word-fall-through).
- Declaration order, fixed because existing benches connect by position: readReady, writeReady, readValid, writeValid, writeData, readData, clk, rst.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- While rst=1 at a rising edge: write pointer, read pointer and count are cleared to 0. Memory contents are not cleared.
- Outputs while rst is high: readReady=0, writeReady=0, readData=0.
- First cycle after reset release: writeReady=1, readReady=0.
- Ready outputs: writeReady = !rst && (count != FIFO_DEPTH); readReady = !rst && (count != 0). Both are combinational from registered state only and never depend on same-cycle valid inputs.
- Write: when writeValid && writeReady at a rising edge, mem[wr_ptr] <= writeData and wr_ptr increments.
- Read: when readValid && readReady at a rising edge, rd_ptr increments, which pops the head.
- readData = mem[rd_ptr] combinationally when count != 0, else 0. Read latency is zero: data is valid in the same cycle readReady is high.
- Write-to-read latency: data written at edge N appears on readData (with readReady=1) after edge N, provided the FIFO was empty.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally from FIFO_DEPTH-1 to 0.
- count is log2(FIFO_DEPTH)+1 bits wide.
- count update per edge: +1 on write only, -1 on read only, unchanged on simultaneous read and write, unchanged on neither.
- Full (count = FIFO_DEPTH): writeValid is ignored. A simultaneous read pops normally, and writeReady returns to 1 the next cycle.
- Empty (count = 0): readValid is ignored. A simultaneous write is accepted, and readReady rises the next cycle.
- Simultaneous read and write at non-empty, non-full occupancy: both occur and order is preserved.
- Ignored requests are not queued. A valid held without ready has no effect until ready is seen.
- Reset asserted mid-operation: all queued data is discarded and the FIFO is empty after that edge.
- Ordering: strict FIFO; no data is lost or duplicated.

Decomposition:
- Shared package holds:
  - default width and depth constants;
  - a pointer-width constant, computed as ceiling log2 of the depth.
- One natural sub-module, fifo_mem: a simple dual-port array with one synchronous write port and one asynchronous read port.
- The pointer and count logic stays in fifo.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> while high readReady=0, writeReady=0, readData=0; after release writeReady=1, readReady=0.
- Single transfer: write 8'hA5 with readValid=0 -> next cycle readReady=1 and readData=8'hA5; pulse readValid -> readReady=0 the following cycle.
- Fill to full with DEPTH=256: write values 0..255 -> writeReady=0 after the 256th accepted write; a 257th write of 8'hFF is dropped; reading back 256 entries yields 0..255 in order, then readReady=0.
- Full with simultaneous read and write: at count=256 assert both valids -> only the pop occurs, count=255, writeReady=1 next cycle; the dropped data never appears on readData.
- Wrap-around and concurrency: random writes at about 1/5 probability and reads at about 1/3 over 50,000 cycles -> readData sequence matches a scoreboard queue, with no overflow or underflow and count within 0..256.
- Reset mid-stream: with 10 entries queued, assert rst for 1 cycle -> readReady=0; a subsequent write of 8'h3C is the first data read out.
